// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: START/WRITE/READ/STOP over valid/ready, open-drain SCL/SDA drive.
// Optional macro I2C_CLK_STRETCH_EN: quarter counter holds while a slave stretches SCL low.
module i2c_master_byte #(
    parameter int CLK_DIV = 250,
    parameter int Q_W     = 16
) (
    input  logic       clk,
    input  logic       start_rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_data,
    input  logic       cmd_ack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       rsp_err,
    output logic       busy,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       scl_i,
    input  logic       sda_i
);
    localparam logic [1:0]     C_START = 2'b00;
    localparam logic [1:0]     C_WRITE = 2'b01;
    localparam logic [1:0]     C_READ  = 2'b10;
    localparam logic [Q_W-1:0] Q_LAST  = Q_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_DONE} state_t;

    state_t         r_state;
    logic [Q_W-1:0] r_qcnt;
    logic [1:0]     r_quarter;
    logic [3:0]     r_bit;
    logic [7:0]     r_tx;
    logic [8:0]     r_rx;
    logic           r_is_read;
    logic           r_ready;
    logic           r_valid;
    logic [7:0]     r_data;
    logic           r_nack;
    logic           r_err;
    logic           r_busy;
    logic           r_scl;
    logic           r_sda;

    logic w_hold;
    logic w_active;
    logic w_qend;
    logic w_last;

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] r_scl_sync;

    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) r_scl_sync <= 2'b11;
        else           r_scl_sync <= {r_scl_sync[0], scl_i};
    end

    // Slave holds SCL low while we release it: freeze the quarter.
    assign w_hold = r_scl && !r_scl_sync[1];
`else
    logic w_unused;
    assign w_unused = scl_i;
    assign w_hold   = 1'b0;
`endif

    assign w_active = (r_state == S_START) || (r_state == S_BIT) || (r_state == S_STOP);
    assign w_qend   = w_active && !w_hold && (r_qcnt == Q_LAST);
    assign w_last   = w_qend && (r_quarter == 2'd3) && ((r_state != S_BIT) || (r_bit == 4'd8));

    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) begin
            r_state   <= S_IDLE;
            r_qcnt    <= '0;
            r_quarter <= 2'd0;
            r_bit     <= 4'd0;
            r_tx      <= 8'hFF;
            r_rx      <= '0;
            r_is_read <= 1'b0;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_data    <= 8'h00;
            r_nack    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_scl     <= 1'b1;
            r_sda     <= 1'b1;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    if (cmd_valid) begin
                        r_qcnt    <= '0;
                        r_quarter <= 2'd0;
                        r_bit     <= 4'd0;
                        r_rx      <= '0;
                        r_is_read <= (cmd == C_READ);
                        // Remaining bits after the first; the 9th is release (WRITE) or ~ack (READ).
                        r_tx      <= (cmd == C_WRITE) ? {cmd_data[6:0], 1'b1} : {7'h7F, ~cmd_ack};
                        if ((cmd != C_START) && !r_busy) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b1;
                            r_err   <= 1'b1;
                            r_nack  <= 1'b0;
                        end else begin
                            r_ready <= 1'b0;
                            case (cmd)
                                C_START: begin
                                    r_state <= S_START;
                                    r_sda   <= 1'b1;
                                end
                                C_WRITE, C_READ: begin
                                    r_state <= S_BIT;
                                    r_scl   <= 1'b0;
                                    r_sda   <= (cmd == C_WRITE) ? cmd_data[7] : 1'b1;
                                end
                                default: begin
                                    r_state <= S_STOP;
                                    r_scl   <= 1'b0;
                                    r_sda   <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    if (!w_hold) r_qcnt <= w_qend ? '0 : r_qcnt + 1'b1;
                    if (w_qend) begin
                        r_quarter <= r_quarter + 2'd1;
                        case (r_quarter)
                            2'd0: r_scl <= 1'b1;
                            2'd1: begin
                                if (r_state == S_BIT) r_rx <= {r_rx[7:0], sda_i};
                                if (r_state == S_START) r_sda <= 1'b0;
                                if (r_state == S_STOP)  r_sda <= 1'b1;
                            end
                            2'd2: if (r_state != S_STOP) r_scl <= 1'b0;
                            default: begin
                                if (r_state == S_START) r_busy <= 1'b1;
                                if (r_state == S_STOP)  r_busy <= 1'b0;
                                if ((r_state == S_BIT) && (r_bit != 4'd8)) begin
                                    r_bit <= r_bit + 4'd1;
                                    r_sda <= r_tx[7];
                                    r_tx  <= {r_tx[6:0], 1'b1};
                                end
                            end
                        endcase
                    end
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b1;
                        r_ready <= 1'b1;
                        r_err   <= 1'b0;
                        r_nack  <= (r_state == S_BIT) && !r_is_read && r_rx[0];
                        if ((r_state == S_BIT) && r_is_read) r_data <= r_rx[8:1];
                    end
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign rsp_valid = r_valid;
    assign rsp_data  = r_data;
    assign rsp_nack  = r_nack;
    assign rsp_err   = r_err;
    assign busy      = r_busy;
    assign scl_o     = r_scl;
    assign sda_o     = r_sda;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Scoreboard bench for i2c_master_byte: behavioural slave, bus decoder and latency/response model.
`timescale 1ns/1ps
module tb_i2c_master_byte;
    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       start_rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ack = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_nack, rsp_err, busy, scl_o, sda_o;
    logic [7:0] rsp_data;
    logic       scl_i, sda_i;
    logic       stretch = 1'b0;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       nack;
        logic       err;
        logic       busy;
        int         rises;
        int         starts;
        int         stops;
        logic       chk_bits;
        logic [8:0] bits;
    } exp_t;
    exp_t sb[$];

    logic       m_busy = 1'b0;
    logic [7:0] m_data = 8'h00;
    int m_rises = 0, m_starts = 0, m_stops = 0;

    int d_rises = 0, d_starts = 0, d_stops = 0;
    logic [8:0] d_bits = '0;
    logic p_scl = 1'b1, p_sda = 1'b1;

    int fall_cnt = 0;
    int slv_base = 0;
    logic slv_act = 1'b0, slv_rd = 1'b0, slv_ack = 1'b0;
    logic [7:0] slv_byte = 8'h00;
    logic slv_drv;

    i2c_master_byte #(.CLK_DIV(Q), .Q_W(16)) dut (
        .clk(clk), .start_rst(start_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .cmd_data(cmd_data), .cmd_ack(cmd_ack), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_nack(rsp_nack), .rsp_err(rsp_err), .busy(busy),
        .scl_o(scl_o), .sda_o(sda_o), .scl_i(scl_i), .sda_i(sda_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge scl_o) fall_cnt <= fall_cnt + 1;

    // Slave: bit k of the current transfer is presented after the k-th SCL fall.
    always_comb begin
        int b;
        b = fall_cnt - slv_base;
        slv_drv = 1'b1;
        if (slv_act) begin
            if (slv_rd) begin
                if (b < 8) slv_drv = slv_byte[7-b];
            end else if (b == 8) begin
                slv_drv = ~slv_ack;
            end
        end
    end

    assign sda_i = sda_o & slv_drv;
    assign scl_i = scl_o & ~stretch;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Bus decoder: SCL rises capture data; SDA edges during SCL high are START/STOP.
    always @(negedge clk) begin
        if (start_rst) begin
            d_rises = 0; d_starts = 0; d_stops = 0; d_bits = '0;
        end else begin
            if (scl_o && !p_scl) begin
                d_rises++;
                d_bits = {d_bits[7:0], sda_o};
            end
            if (scl_o && p_scl && (sda_o != p_sda)) begin
                if (sda_o) d_stops++;
                else       d_starts++;
            end
        end
        p_scl = scl_o;
        p_sda = sda_o;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!start_rst && rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = sb.pop_front();
`ifdef I2C_CLK_STRETCH_EN
                chk("latency_min", (cyc >= e.cyc) ? 1 : 0, 1);
`else
                chk("latency", cyc, e.cyc);
`endif
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_nack", rsp_nack, e.nack);
                chk("rsp_err", rsp_err, e.err);
                chk("busy", busy, e.busy);
                chk("scl_rises", d_rises, e.rises);
                chk("starts", d_starts, e.starts);
                chk("stops", d_stops, e.stops);
                chk("cmd_ready_at_rsp", cmd_ready, 1);
                if (e.chk_bits) chk("sda_bits", d_bits, e.bits);
                if (e.err) chk("lines_idle", {scl_o, sda_o}, 2'b11);
            end
        end
    end

    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic a,
                         input logic sa, input logic [7:0] sbyte, input int extra);
        exp_t e;
        int n;
        logic legal;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        legal    = (c == 2'b00) || m_busy;
        slv_base = fall_cnt;
        slv_act  = legal && ((c == 2'b01) || (c == 2'b10));
        slv_rd   = (c == 2'b10);
        slv_ack  = sa;
        slv_byte = sbyte;
        cmd = c; cmd_data = d; cmd_ack = a; cmd_valid = 1'b1;
        e.data = m_data; e.nack = 1'b0; e.err = !legal; e.chk_bits = 1'b0; e.bits = '0;
        if (!legal) begin
            e.cyc = cyc + 1;
        end else begin
            case (c)
                2'b00: begin
                    e.cyc = cyc + 1 + 4*Q;
                    if (m_busy) m_rises++;
                    m_starts++;
                    m_busy = 1'b1;
                end
                2'b11: begin
                    e.cyc = cyc + 1 + 4*Q;
                    m_rises++;
                    m_stops++;
                    m_busy = 1'b0;
                end
                default: begin
                    e.cyc = cyc + 1 + 36*Q + extra;
                    m_rises += 9;
                    e.chk_bits = 1'b1;
                    if (c == 2'b01) begin
                        e.nack = !sa;
                        e.bits = {d, 1'b1};
                    end else begin
                        m_data = sbyte;
                        e.data = sbyte;
                        e.bits = {8'hFF, ~a};
                    end
                end
            endcase
        end
        e.busy = m_busy; e.rises = m_rises; e.starts = m_starts; e.stops = m_stops;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        start_rst = 1'b0;
        @(negedge clk);
        chk("rst_scl", scl_o, 1);
        chk("rst_sda", sda_o, 1);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_nack", rsp_nack, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);

        issue(2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 0);
        issue(2'b01, 8'hAA, 1'b0, 1'b1, 8'h00, 0);
        issue(2'b01, 8'h55, 1'b0, 1'b0, 8'h00, 0);
        issue(2'b10, 8'h00, 1'b0, 1'b0, 8'h3C, 0);
        issue(2'b10, 8'h00, 1'b1, 1'b0, 8'(($urandom)), 0);
        issue(2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 0);
        issue(2'b11, 8'h00, 1'b0, 1'b0, 8'h00, 0);
        issue(2'b01, 8'h12, 1'b0, 1'b1, 8'h00, 0);
        issue(2'b10, 8'h00, 1'b1, 1'b0, 8'h99, 0);
        issue(2'b11, 8'h00, 1'b0, 1'b0, 8'h00, 0);
        drain();

`ifdef I2C_CLK_STRETCH_EN
        begin
            int n;
            issue(2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 0);
            issue(2'b01, 8'hC3, 1'b0, 1'b1, 8'h00, 20);
            n = 0;
            while (!scl_o && n < 1000) begin
                @(negedge clk);
                n++;
            end
            stretch = 1'b1;
            repeat (20) @(negedge clk);
            stretch = 1'b0;
            issue(2'b11, 8'h00, 1'b0, 1'b0, 8'h00, 0);
            drain();
        end
`endif

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        if (!m_busy) issue(2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 0);
        issue(2'b01, 8'h0F, 1'b0, 1'b1, 8'h00, 0);
        repeat (40) @(negedge clk);
        sb.delete();
        #2 start_rst = 1'b1;
        #1;
        chk("async_rst_scl", scl_o, 1);
        chk("async_rst_sda", sda_o, 1);
        repeat (2) @(negedge clk);
        start_rst = 1'b0;
        m_busy = 1'b0; m_data = 8'h00; m_rises = 0; m_starts = 0; m_stops = 0;
        slv_act = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);
        repeat (200) @(negedge clk);

        issue(2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 0);
        issue(2'b11, 8'h00, 1'b0, 1'b0, 8'h00, 0);
        drain();
        chk("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
